// File: rtl/sid_filter_sched_if.sv
// Bus bundle for sid_filter_sched: register writes, filter link, PCM stream, status.
interface sid_filter_sched_if;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        filt_clk_enable;
   logic [10:0] reg_fc;
   logic [7:0]  res_filt;
   logic [7:0]  mode_vol;
   logic [14:0] filt_sample;
   logic        filt_sample_ready;
   logic [14:0] pcm_out;
   logic        pcm_valid;
   logic        pcm_ready;
   logic        clr_ovr;
   logic [7:0]  ovr_cnt;
   logic        desync_err;

   modport slave (
      input  wr_en, wr_addr, wr_data, filt_sample, filt_sample_ready, pcm_ready, clr_ovr,
      output filt_clk_enable, reg_fc, res_filt, mode_vol, pcm_out, pcm_valid, ovr_cnt, desync_err
   );

   modport master (
      output wr_en, wr_addr, wr_data, filt_sample, filt_sample_ready, pcm_ready, clr_ovr,
      input  filt_clk_enable, reg_fc, res_filt, mode_vol, pcm_out, pcm_valid, ovr_cnt, desync_err
   );
endinterface

// File: rtl/sid_filter_sched.sv
// SID filter sequencer: step strobe, live filter config, 2-entry PCM output FIFO.
// Optional SID_SCHED_SHADOW_EN: config writes are held in shadows until the step-7 commit.
module sid_filter_sched #(
   parameter int DIV = 4
) (
   input logic                 clk,
   input logic                 rst,
   sid_filter_sched_if.slave   bus
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] presc;
   logic          strobe;
   logic [2:0]    step;
   logic          desync;

   assign strobe              = (presc == PW'(DIV - 1));
   assign bus.filt_clk_enable = strobe & ~rst;

   always_ff @(posedge clk) begin
      if (rst) presc <= '0;
      else     presc <= strobe ? '0 : presc + 1'b1;
   end

   // A ready from the filter always means it is at step 0, so resync to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         step   <= 3'd0;
         desync <= 1'b0;
      end else if (strobe) begin
         step   <= bus.filt_sample_ready ? 3'd1 : step + 3'd1;
         desync <= desync | (bus.filt_sample_ready != (step == 3'd0));
      end
   end
   assign bus.desync_err = desync;

   logic [10:0] fc_q, fc_base, fc_n;
   logic [7:0]  rf_q, rf_base, rf_n;
   logic [7:0]  mv_q, mv_base, mv_n;

   always_comb begin
      fc_n = fc_base;
      rf_n = rf_base;
      mv_n = mv_base;
      if (bus.wr_en) begin
         case (bus.wr_addr)
            5'h15:   fc_n[2:0]  = bus.wr_data[2:0];
            5'h16:   fc_n[10:3] = bus.wr_data;
            5'h17:   rf_n       = bus.wr_data;
            5'h18:   mv_n       = bus.wr_data;
            default: ;
         endcase
      end
   end

`ifdef SID_SCHED_SHADOW_EN
   logic [10:0] fc_sh;
   logic [7:0]  rf_sh, mv_sh;
   logic        commit;

   assign commit  = strobe && (step == 3'd7);
   assign fc_base = fc_sh;
   assign rf_base = rf_sh;
   assign mv_base = mv_sh;

   // Commit takes shadow-next so a write in the commit cycle is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         fc_sh <= '0; rf_sh <= '0; mv_sh <= '0;
         fc_q  <= '0; rf_q  <= '0; mv_q  <= '0;
      end else begin
         fc_sh <= fc_n; rf_sh <= rf_n; mv_sh <= mv_n;
         if (commit) begin
            fc_q <= fc_n; rf_q <= rf_n; mv_q <= mv_n;
         end
      end
   end
`else
   assign fc_base = fc_q;
   assign rf_base = rf_q;
   assign mv_base = mv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fc_q <= '0; rf_q <= '0; mv_q <= '0;
      end else begin
         fc_q <= fc_n; rf_q <= rf_n; mv_q <= mv_n;
      end
   end
`endif

   assign bus.reg_fc   = fc_q;
   assign bus.res_filt = rf_q;
   assign bus.mode_vol = mv_q;

   // Shift-style FIFO: e0 is the head and simply holds its value once drained.
   logic [14:0] e0, e1;
   logic [1:0]  cnt;
   logic        push, pop, acc, drop;
   logic [7:0]  ovr;

   assign push = strobe && bus.filt_sample_ready;
   assign pop  = (cnt != 2'd0) && bus.pcm_ready;
   assign acc  = push && ((cnt != 2'd2) || pop);
   assign drop = push && !acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= 2'd0;
      end else if (pop && acc) begin
         if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= bus.filt_sample;
         end else begin
            e0 <= bus.filt_sample;
         end
      end else if (pop) begin
         if (cnt == 2'd2) e0 <= e1;
         cnt <= cnt - 2'd1;
      end else if (acc) begin
         if (cnt == 2'd0) e0 <= bus.filt_sample;
         else             e1 <= bus.filt_sample;
         cnt <= cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                         ovr <= 8'd0;
      else if (bus.clr_ovr)            ovr <= 8'd0;
      else if (drop && ovr != 8'hFF)   ovr <= ovr + 8'd1;
   end

   assign bus.pcm_out   = e0;
   assign bus.pcm_valid = (cnt != 2'd0);
   assign bus.ovr_cnt   = ovr;
endmodule

// File: tb/tb_sid_filter_sched.sv
// Bench for sid_filter_sched (DIV=4): filter model, PCM scoreboard, register table, corner sequences.
module tb_sid_filter_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_rdy = 1'b0;
   logic [2:0]  fstep;
   logic [14:0] samp;
   int n_chk = 0;
   int n_err = 0;
   int exp_ovr = 0;
   logic [14:0] q[$];

   always #5 clk = ~clk;

   sid_filter_sched_if bus();
   sid_filter_sched #(.DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Filter model: reports ready at its step 0 and moves to a new sample each frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         fstep <= 3'd0;
         samp  <= 15'h4000;
      end else if (bus.filt_clk_enable) begin
         fstep <= bus.filt_sample_ready ? 3'd1 : fstep + 3'd1;
         if (bus.filt_sample_ready) samp <= samp + 15'h0101;
      end
   end
   assign bus.filt_sample       = samp;
   assign bus.filt_sample_ready = force_rdy | (fstep == 3'd0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: predicts FIFO occupancy, head values and overflow count.
   always @(negedge clk) begin
      int  s;
      bit  pop, drop;
      logic [14:0] e;
      if (rst) begin
         q.delete();
         exp_ovr = 0;
      end else begin
         s    = q.size();
         drop = 1'b0;
         chk("pcm_valid", {31'd0, bus.pcm_valid}, {31'd0, s != 0});
         chk("ovr_cnt", {24'd0, bus.ovr_cnt}, exp_ovr);
         pop = (s != 0) && bus.pcm_ready;
         if (pop) begin
            e = q.pop_front();
            chk("pcm_out", {17'd0, bus.pcm_out}, {17'd0, e});
         end
         if (bus.filt_clk_enable && bus.filt_sample_ready) begin
            if (s < 2 || pop) q.push_back(bus.filt_sample);
            else              drop = 1'b1;
         end
         if (bus.clr_ovr)               exp_ovr = 0;
         else if (drop && exp_ovr < 255) exp_ovr++;
      end
   end

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_strobe(input logic [2:0] s);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (bus.filt_clk_enable && fstep == s) ok = 1'b1;
      end
      if (!ok) begin
         n_chk++; n_err++;
         $display("FAIL wait_strobe: no strobe at step %0d within 400 cycles", s);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [4:0]  a;
      logic [7:0]  d;
      logic [10:0] fc;
      logic [7:0]  rf;
      logic [7:0]  mv;
   } vec_t;
   vec_t tbl[10];

   logic [7:0] mv_pre;

   initial begin
      tbl[0] = '{5'h15, 8'hFF, 11'h007, 8'h00, 8'h00};
      tbl[1] = '{5'h16, 8'hAB, 11'h55F, 8'h00, 8'h00};
      tbl[2] = '{5'h1A, 8'h12, 11'h55F, 8'h00, 8'h00};
      tbl[3] = '{5'h17, 8'hA5, 11'h55F, 8'hA5, 8'h00};
      tbl[4] = '{5'h18, 8'h1F, 11'h55F, 8'hA5, 8'h1F};
      tbl[5] = '{5'h14, 8'hFF, 11'h55F, 8'hA5, 8'h1F};
      tbl[6] = '{5'h15, 8'h00, 11'h558, 8'hA5, 8'h1F};
      tbl[7] = '{5'h1F, 8'h77, 11'h558, 8'hA5, 8'h1F};
      tbl[8] = '{5'h16, 8'h00, 11'h000, 8'hA5, 8'h1F};
      tbl[9] = '{5'h19, 8'hC3, 11'h000, 8'hA5, 8'h1F};

      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.pcm_ready = 1'b1; bus.clr_ovr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, then strobe on cycles 4, 8, 12, ...
      @(negedge clk);
      chk("rst_enable", {31'd0, bus.filt_clk_enable}, 32'd0);
      chk("rst_fc", {21'd0, bus.reg_fc}, 32'd0);
      chk("rst_rf_mv", {16'd0, bus.res_filt, bus.mode_vol}, 32'd0);
      chk("rst_pcm", {16'd0, bus.pcm_out, bus.pcm_valid}, 32'd0);
      chk("rst_status", {23'd0, bus.ovr_cnt, bus.desync_err}, 32'd0);
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         chk("strobe_phase", {31'd0, bus.filt_clk_enable}, {31'd0, ((k + 1) % 4) == 0});
      end

      // Write mode_vol at step 3; visible immediately or only after the step-7 commit.
      wait_strobe(3'd2);
      wr(5'h18, 8'h1F);
      @(negedge clk);
`ifdef SID_SCHED_SHADOW_EN
      mv_pre = 8'h00;
`else
      mv_pre = 8'h1F;
`endif
      chk("mv_after_wr", {24'd0, bus.mode_vol}, {24'd0, mv_pre});
      wait_strobe(3'd7);
      chk("mv_before_commit", {24'd0, bus.mode_vol}, {24'd0, mv_pre});
      @(negedge clk);
      chk("mv_after_commit", {24'd0, bus.mode_vol}, 32'h1F);

      // Forced ready at step 4: sticky desync, step reloads to 1 (checked via commit timing).
      chk("desync_clear", {31'd0, bus.desync_err}, 32'd0);
      wait_strobe(3'd3);
      @(posedge clk); #1 force_rdy = 1'b1;
      wait_strobe(3'd4);
      @(posedge clk); #1 force_rdy = 1'b0;
      @(negedge clk);
      chk("desync_set", {31'd0, bus.desync_err}, 32'd1);
      wait_strobe(3'd2);
      wr(5'h18, 8'h2A);
      @(negedge clk);
`ifdef SID_SCHED_SHADOW_EN
      mv_pre = 8'h1F;
`else
      mv_pre = 8'h2A;
`endif
      chk("resync_mv_wr", {24'd0, bus.mode_vol}, {24'd0, mv_pre});
      wait_strobe(3'd7);
      chk("resync_mv_pre", {24'd0, bus.mode_vol}, {24'd0, mv_pre});
      @(negedge clk);
      chk("resync_mv_post", {24'd0, bus.mode_vol}, 32'h2A);
      chk("desync_sticky", {31'd0, bus.desync_err}, 32'd1);

      // Consumer stalled for 4 frames: two kept, two dropped, then cleared.
      wait_strobe(3'd1);
      @(posedge clk); #1 bus.pcm_ready = 1'b0;
      repeat (128) @(posedge clk);
      @(negedge clk);
      chk("ovr_after_stall", {24'd0, bus.ovr_cnt}, 32'd2);
      chk("valid_in_stall", {31'd0, bus.pcm_valid}, 32'd1);
      @(posedge clk); #1 bus.clr_ovr = 1'b1;
      @(posedge clk); #1 bus.clr_ovr = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", {24'd0, bus.ovr_cnt}, 32'd0);
      @(posedge clk); #1 bus.pcm_ready = 1'b1;
      repeat (20) @(posedge clk);

      // Mid-frame reset clears everything in one cycle.
      wr(5'h17, 8'h99);
      repeat (37) @(posedge clk);
      do_reset();
      @(negedge clk);
      chk("midrst_regs", {bus.reg_fc, bus.res_filt, bus.mode_vol}, 32'd0);
      chk("midrst_status", {22'd0, bus.ovr_cnt, bus.desync_err, bus.pcm_valid}, 32'd0);
      chk("midrst_pcm_out", {17'd0, bus.pcm_out}, 32'd0);

      // Register map table: each write given more than a frame to reach the live outputs.
      for (int i = 0; i < 10; i++) begin
         wr(tbl[i].a, tbl[i].d);
         repeat (40) @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_fc", i), {21'd0, bus.reg_fc}, {21'd0, tbl[i].fc});
         chk($sformatf("tbl%0d_rf", i), {24'd0, bus.res_filt}, {24'd0, tbl[i].rf});
         chk($sformatf("tbl%0d_mv", i), {24'd0, bus.mode_vol}, {24'd0, tbl[i].mv});
      end

      repeat (40) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
